// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1) with a valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity) and the parity_err pulse.
module uart_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int HALF  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic              par_bit_q, par_bit_d;
    logic              parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic tick;
    logic samp_last;
    logic complete;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], rx};
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        tick         = 1'b0;
        complete     = 1'b0;
        samp_last    = (samp_cnt_q == OS_W'(OVERSAMPLE - 1));

        // Holding the divider at zero in IDLE phase-aligns sampling to the start edge.
        if (state_q == S_IDLE) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == DIV_W'(DIV - 1)) begin
            tick_cnt_d = '0;
            tick       = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                samp_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_cnt_q == OS_W'(HALF - 1)) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = 3'd0;
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (samp_last) begin
                        samp_cnt_d         = '0;
                        shift_d[bit_idx_q] = rx_s;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (samp_last) begin
                        samp_cnt_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = S_STOP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (samp_last) begin
                        samp_cnt_d = '0;
                        if (!rx_s) begin
                            // A bad stop bit outranks a parity error on the same frame.
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end else begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if ((^shift_q ^ par_bit_q) != PARITY_ODD) begin
                                parity_err_d = 1'b1;
                            end else begin
                                complete = 1'b1;
                            end
`else
                            complete = 1'b1;
`endif
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            tick_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; a frame-level model predicts bytes and error pulses.
// Runs at a scaled-down baud rate (DIV=4, 64 clocks per bit) to keep frames short.
module tb_uart_rx;

    localparam int OS      = 16;
    localparam int DIVB    = 4;
    localparam int BAUD_TB = 1000;
    localparam int CLK_TB  = BAUD_TB * OS * DIVB;
    localparam int BIT     = OS * DIVB;
    localparam int LAT_LO  = (19 * BIT) / 2;
    localparam int LAT_HI  = LAT_LO + 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .CLK_HZ    (CLK_TB),
        .BAUD      (BAUD_TB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vhigh_cnt = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records handshakes and error pulses away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (valid && ready) got_q.push_back(data);
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
                if (parity_err) pe_cnt++;
`endif
                if (valid) vhigh_cnt++;
                if (valid && !valid_prev) rise_cyc = cyc;
            end
            valid_prev = valid;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    // Leaves rx at the stop-bit level so a bad stop can be extended into a break.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bit);
        rx = 1'b0;
        start_cyc = cyc;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        hold(BIT);
`else
        if (par_bit) begin
            rx = 1'b1;
        end
`endif
        rx = stop_bit;
        hold(BIT);
    endtask

    function automatic bit good_par(input logic [7:0] b);
        return ^b;
    endfunction

    int fe0, ov0, pe0, vh0, lat, nf, kind, kinds;
    logic [7:0] b, first_b;
    bit bad_stop, bad_par;

    initial begin
        // Reset values while rst_n is low.
        hold(3);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        hold(BIT);

        // 0xA5 with ready held high: one-cycle valid, mid-stop completion.
        ready = 1'b1;
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhigh_cnt;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        hold(8);
        lat = rise_cyc - start_cyc;
        check("a5_count", got_q.size(), 1);
        if (got_q.size() > 0) check("a5_data", int'(got_q.pop_front()), 'hA5);
        check("a5_valid_width", vhigh_cnt - vh0, 1);
        check("a5_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        check("a5_latency_in_window", int'(lat >= LAT_LO && lat <= LAT_HI), 1);
        $display("txn a5: latency=%0d cycles (window %0d..%0d)", lat, LAT_LO, LAT_HI);

        // 0x3C then 0xC3 back-to-back with ready low: first byte held, one overrun.
        ready = 1'b0;
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b1, good_par(8'h3C));
        send_frame(8'hC3, 1'b1, good_par(8'hC3));
        hold(4);
        check("ovr_data", int'(data), 'h3C);
        check("ovr_valid", int'(valid), 1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_fe", fe_cnt - fe0, 0);
        ready = 1'b1;
        step();
        check("ovr_drain_valid", int'(valid), 0);
        check("ovr_drain_count", got_q.size(), 1);
        if (got_q.size() > 0) check("ovr_drain_data", int'(got_q.pop_front()), 'h3C);
        $display("txn overrun: held=0x%02h overruns=%0d", data, ov_cnt - ov0);

        // 0x55 with a low stop bit, line held low for three more bits.
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhigh_cnt;
        send_frame(8'h55, 1'b0, good_par(8'h55));
        hold(3 * BIT);
        check("brk_fe", fe_cnt - fe0, 1);
        check("brk_busy_low_line", int'(busy), 1);
        check("brk_no_valid", vhigh_cnt - vh0, 0);
        rx = 1'b1;
        hold(8);
        check("brk_busy_released", int'(busy), 0);
        hold(BIT);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        hold(8);
        check("brk_next_count", got_q.size(), 1);
        if (got_q.size() > 0) check("brk_next_data", int'(got_q.pop_front()), 'h81);
        $display("txn break: frame_err=%0d then byte 0x81", fe_cnt - fe0);

        // Four-clock glitch on an idle line.
        got_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhigh_cnt;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(1);
        check("glitch_busy_seen", int'(busy), 1);
        hold(BIT);
        check("glitch_busy_after", int'(busy), 0);
        check("glitch_no_valid", vhigh_cnt - vh0, 0);
        check("glitch_no_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        $display("txn glitch: rejected");

        // Reset during the data bits of 0xF0, then 0x0F.
        ready = 1'b0;
        got_q.delete();
        rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            hold(BIT);
        end
        rx = 1'b1;
        hold(BIT / 2);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_data", int'(data), 0);
        hold(2);
        rst_n = 1'b1;
        hold(3 * BIT);
        check("midrst_idle_valid", int'(valid), 0);
        send_frame(8'h0F, 1'b1, good_par(8'h0F));
        hold(4);
        check("midrst_valid", int'(valid), 1);
        check("midrst_data_after", int'(data), 'h0F);
        ready = 1'b1;
        step();
        check("midrst_drain_count", got_q.size(), 1);
        if (got_q.size() > 0) check("midrst_drain_data", int'(got_q.pop_front()), 'h0F);
        $display("txn midreset: byte 0x0F delivered");

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07: correct bit is 1.
        got_q.delete();
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        hold(8);
        check("par_ok_count", got_q.size(), 1);
        if (got_q.size() > 0) check("par_ok_data", int'(got_q.pop_front()), 'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        hold(8);
        check("par_bad_pulse", pe_cnt - pe0, 1);
        check("par_bad_count", got_q.size(), 0);
        $display("txn parity: parity_err=%0d", pe_cnt - pe0);
        kinds = 5;
`else
        kinds = 3;
`endif

        // Random frames with ready high: good, bad stop, and (with parity) bad parity / both.
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom);
            kind = $urandom_range(0, kinds - 1);
            bad_stop = (kind == 2) || (kind == 4);
            bad_par = (kind >= 3);
            got_q.delete();
            fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; vh0 = vhigh_cnt;
            hold($urandom_range(1, BIT));
            send_frame(b, !bad_stop, good_par(b) ^ bad_par);
            if (bad_stop) begin
                hold($urandom_range(0, 2 * BIT));
                rx = 1'b1;
            end
            hold(8);
            check("rnd_count", got_q.size(), (bad_stop || bad_par) ? 0 : 1);
            if (got_q.size() > 0) check("rnd_data", int'(got_q.pop_front()), int'(b));
            check("rnd_fe", fe_cnt - fe0, bad_stop ? 1 : 0);
            check("rnd_ov", ov_cnt - ov0, 0);
`ifdef UART_RX_PARITY_EN
            check("rnd_pe", pe_cnt - pe0, (bad_par && !bad_stop) ? 1 : 0);
`endif
            check("rnd_busy", int'(busy), 0);
            $display("txn rnd %0d: byte=0x%02h bad_stop=%0d bad_par=%0d", n, b, bad_stop, bad_par);
        end

        // Random bursts with ready low: first byte is kept, every later one overruns.
        for (int n = 0; n < 3; n++) begin
            nf = $urandom_range(2, 3);
            ready = 1'b0;
            got_q.delete();
            ov0 = ov_cnt;
            first_b = 8'($urandom);
            send_frame(first_b, 1'b1, good_par(first_b));
            for (int k = 1; k < nf; k++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1, good_par(b));
            end
            hold(4);
            check("burst_data", int'(data), int'(first_b));
            check("burst_valid", int'(valid), 1);
            check("burst_ov", ov_cnt - ov0, nf - 1);
            ready = 1'b1;
            step();
            check("burst_drain_valid", int'(valid), 0);
            check("burst_drain_count", got_q.size(), 1);
            if (got_q.size() > 0) check("burst_drain_data", int'(got_q.pop_front()), int'(first_b));
            $display("txn burst %0d: frames=%0d kept=0x%02h", n, nf, first_b);
            hold($urandom_range(1, BIT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
